bist_fail_log: RTL

- Receiving end of the BIST fail-report interface: the BIST controller drives fail/fail_addr while it marches the 256x4 SRAM, and this block captures them.
- Logs distinct failing SRAM addresses into a small FIFO.
- Counts fail events and flags overflow.
- Lets the host/tester read the failing addresses back after, or during, the test. Sits beside the BIST block; shares its clk/rst.

---
 rtl/bist_fail_log_pkg.sv | 26 ++
 rtl/bist_fail_fifo.sv | 84 ++++++++
 rtl/bist_fail_log.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bist_fail_log_pkg.sv
// ---------------------------------------------------------------------------
// bist_fail_log_pkg
// Shared parameters for the BIST fail-logging slice: the SRAM address width
// the BIST marches over, the simulation clock period, default sizing for the
// fail-address log, and the state encoding of the logging FSM.
// ---------------------------------------------------------------------------
package bist_fail_log_pkg;

    // Geometry of the 256x4 SRAM under test and the common clock period.
    localparam int SRAM_ADDR_WIDTH = 8;
    localparam int CLK_PERIOD      = 10;

    // Default sizing of the fail-address log.
    localparam int LOG_ADDR_W = SRAM_ADDR_WIDTH;
    localparam int LOG_DEPTH  = 8;
    localparam int LOG_PTR_W  = $clog2(LOG_DEPTH);
    localparam int LOG_CNT_W  = 9;

    // Logging FSM: waiting for a start, capturing fails, or finished.
    typedef enum logic [1:0] {
        LOG_IDLE    = 2'd0,
        LOG_LOGGING = 2'd1,
        LOG_DONE    = 2'd2
    } log_state_t;

endpackage

// File: rtl/bist_fail_fifo.sv
// ---------------------------------------------------------------------------
// bist_fail_fifo
// DEPTH x ADDR_W synchronous FIFO holding failing SRAM addresses.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             synchronous flush of pointers and count (wins over all)
//   push, push_data   write request and data
//   pop               read request
//   rd_data, rd_valid registered read port, rd_valid pulses one cycle
//   count             entries currently held (0..DEPTH)
//   full, empty       occupancy flags
// A pop on an empty FIFO is ignored. A push on a full FIFO is accepted only
// when a pop frees the slot in the same cycle.
// ---------------------------------------------------------------------------
module bist_fail_fifo #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;
    logic              do_push;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

    // Clear suppresses both sides so a flush cycle never moves data.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered read port. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bist_fail_log.sv
// ---------------------------------------------------------------------------
// bist_fail_log
// Receiving end of the BIST fail-report interface. Captures distinct failing
// SRAM addresses into a small FIFO while the BIST is running, counts fail
// events (saturating) and flags dropped events, and lets the host pop the
// logged addresses at any time.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   bist_start, bist_done  BIST control strobes (start clears and arms)
//   fail, fail_addr        per-cycle compare mismatch and its address
//   rd_en                  host pop request
//   rd_data, rd_valid      popped address, valid one cycle after rd_en
//   log_count, empty, full log occupancy
//   fail_count             distinct fail events since arm, saturating
//   overflow               sticky: an event was dropped on a full log
//   busy, pass             FSM in LOGGING / finished with zero fails
// ---------------------------------------------------------------------------
module bist_fail_log
    import bist_fail_log_pkg::*;
#(
    parameter int ADDR_W = LOG_ADDR_W,
    parameter int DEPTH  = LOG_DEPTH,
    parameter int PTR_W  = LOG_PTR_W,
    parameter int CNT_W  = LOG_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bist_start,
    input  logic              bist_done,
    input  logic              fail,
    input  logic [ADDR_W-1:0] fail_addr,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [PTR_W:0]    log_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              overflow,
    output logic              empty,
    output logic              full,
    output logic              busy,
    output logic              pass
);

    log_state_t        state;
    logic [ADDR_W-1:0] last_addr;
    logic              last_valid;
    logic              fail_event;
    logic              pop_ok;
    logic              push_ok;

    // A fail held high on the same address across consecutive cycles is one
    // event; any change of address or a gap with fail=0 starts a new one.
    assign fail_event = (state == LOG_LOGGING) && !bist_start && fail &&
                        !(last_valid && (fail_addr == last_addr));

    // A pop in the same cycle frees a slot, so a full log can still accept.
    assign pop_ok  = rd_en && !empty;
    assign push_ok = fail_event && (!full || pop_ok);

    assign busy = (state == LOG_LOGGING);
    assign pass = (state == LOG_DONE) && (fail_count == '0);

    bist_fail_fifo #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bist_start),
        .push      (push_ok),
        .push_data (fail_addr),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (log_count),
        .full      (full),
        .empty     (empty)
    );

    // Control FSM plus the dedup tracker, event counter and overflow flag.
    // bist_start re-arms from any state and outranks every other input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOG_IDLE;
            last_addr  <= '0;
            last_valid <= 1'b0;
            fail_count <= '0;
            overflow   <= 1'b0;
        end else if (bist_start) begin
            state      <= LOG_LOGGING;
            last_valid <= 1'b0;
            fail_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (fail) begin
                last_addr  <= fail_addr;
                last_valid <= 1'b1;
            end else begin
                last_valid <= 1'b0;
            end

            if (fail_event) begin
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (!push_ok) begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                LOG_IDLE:    state <= LOG_IDLE;
                LOG_LOGGING: if (bist_done) state <= LOG_DONE;
                LOG_DONE:    state <= LOG_DONE;
                default:     state <= LOG_IDLE;
            endcase
        end
    end

endmodule
